// File: rtl/hazard_controller.sv
// Hazard sequencing beside the forwarding unit: load-use bubble, branch flush, mul/div freeze.
// Optional stall/flush statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_controller #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] IF_ID_rs,
  input  logic [4:0] IF_ID_rt,
  input  logic       IF_ID_useRt,
  input  logic       ID_EX_memRead,
  input  logic [4:0] ID_EX_rt,
  input  logic       branch_taken,
  input  logic       md_start,
  input  logic       md_op,
  output logic       PC_write,
  output logic       IF_ID_write,
  output logic       IF_ID_flush,
  output logic       ID_EX_bubble,
  output logic       EX_hold,
  output logic       md_busy,
  output logic       md_done
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  // state   | meaning
  // RUN     | normal issue; branch flush and load-use bubble applied here
  // MD_BUSY | mul/div occupying EX; front of pipe frozen until cnt reaches 0

  typedef enum logic {RUN, MD_BUSY} state_t;

  // The start cycle is the first EX cycle, and the terminal cycle is cnt==0.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             load_use;

  assign load_use = ID_EX_memRead && (ID_EX_rt != 5'd0) &&
                    ((ID_EX_rt == IF_ID_rs) || (IF_ID_useRt && (ID_EX_rt == IF_ID_rt)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      RUN: begin
        if (md_start) begin
          state_next = MD_BUSY;
          cnt_next   = md_op ? DIV_LOAD : MUL_LOAD;
        end
      end
      MD_BUSY: begin
        if (cnt == '0) state_next = RUN;
        else           cnt_next   = cnt - 1'b1;
      end
      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    EX_hold      = 1'b0;
    md_busy      = 1'b0;
    md_done      = 1'b0;
    if (!rst_n) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_bubble = 1'b1;
    end else if (state == MD_BUSY) begin
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      EX_hold     = 1'b1;
      md_busy     = 1'b1;
      md_done     = (cnt == '0);
    end else if (branch_taken) begin
      // Squashing the dependent instruction makes any load-use irrelevant.
      IF_ID_flush  = 1'b1;
      ID_EX_bubble = 1'b1;
    end else if (load_use) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_bubble = 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!PC_write && (stall_cycles != 16'hFFFF))
        stall_cycles <= stall_cycles + 16'd1;
      if ((state == RUN) && branch_taken && (flush_count != 16'hFFFF))
        flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: expected output vectors queued at drive time, compared mid-cycle.
// Stats counters are checked only when HAZARD_STATS_EN is defined.
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] IF_ID_rs, IF_ID_rt, ID_EX_rt;
  logic       IF_ID_useRt, ID_EX_memRead, branch_taken, md_start, md_op;
  logic       PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_hold, md_busy, md_done;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cycles, flush_count;
`endif

  always #5 clk = ~clk;

  hazard_controller #(.MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .IF_ID_useRt(IF_ID_useRt),
    .ID_EX_memRead(ID_EX_memRead), .ID_EX_rt(ID_EX_rt),
    .branch_taken(branch_taken), .md_start(md_start), .md_op(md_op),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_bubble(ID_EX_bubble), .EX_hold(EX_hold), .md_busy(md_busy), .md_done(md_done)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_hold, md_busy, md_done}
  logic [6:0] outs;
  assign outs = {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_hold, md_busy, md_done};

  localparam logic [6:0] V_DEF   = 7'b1100000;
  localparam logic [6:0] V_STALL = 7'b0001000;
  localparam logic [6:0] V_RST   = 7'b0001000;
  localparam logic [6:0] V_FLUSH = 7'b1111000;
  localparam logic [6:0] V_BUSY  = 7'b0000110;
  localparam logic [6:0] V_DONE  = 7'b0000111;

  typedef struct {
    logic [6:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t ent;
  int   checks = 0;
  int   errors = 0;

  // Drives one cycle of inputs and records what the outputs must be during that cycle.
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic use_rt,
                       input logic mem_rd, input logic [4:0] ex_rt, input logic br,
                       input logic st, input logic op, input logic [6:0] e, input string nm);
    IF_ID_rs      = rs;
    IF_ID_rt      = rt;
    IF_ID_useRt   = use_rt;
    ID_EX_memRead = mem_rd;
    ID_EX_rt      = ex_rt;
    branch_taken  = br;
    md_start      = st;
    md_op         = op;
    sb.push_back('{e, nm});
  endtask

  task automatic idle(input logic [6:0] e, input string nm);
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, e, nm);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, V_RST, "reset_outputs");
    @(negedge clk);
    ent = sb.pop_front(); checks++;
    if (outs !== ent.exp) begin errors++; $display("FAIL %s: got %b expected %b", ent.name, outs, ent.exp); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      idle(V_DEF, "after_reset_default");
      @(negedge clk);
      ent = sb.pop_front(); checks++;
      if (outs !== ent.exp) begin errors++; $display("FAIL %s: got %b expected %b", ent.name, outs, ent.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: drive(5'd5, 5'd3, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, V_STALL, "load_use_rs");
        1: drive(5'd5, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, V_DEF,   "load_use_cleared");
        2: drive(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, V_STALL, "load_use_rt");
        3: drive(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, V_DEF,   "rt_not_used");
        4: drive(5'd4, 5'd6, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, V_DEF,   "no_reg_match");
        5: drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, V_DEF,   "load_r0_no_stall");
        default: drive(5'd9, 5'd9, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, V_DEF, "no_load_no_stall");
      endcase
      @(negedge clk);
      ent = sb.pop_front(); checks++;
      if (outs !== ent.exp) begin errors++; $display("FAIL %s: got %b expected %b", ent.name, outs, ent.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_load;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: drive(5'd5, 5'd3, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, V_FLUSH, "branch_over_load_use");
        1: idle(V_DEF, "after_branch_default");
        default: drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, V_FLUSH, "branch_plain");
      endcase
      @(negedge clk);
      ent = sb.pop_front(); checks++;
      if (outs !== ent.exp) begin errors++; $display("FAIL %s: got %b expected %b", ent.name, outs, ent.exp); end
      @(posedge clk); #1;
    end
  endtask

  // Divide: 31 frozen cycles after start, done on the 31st; hazards during the freeze are ignored.
  task automatic test_div;
    for (int i = 0; i <= 32; i++) begin
      if (i == 0)
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, V_DEF, "div_start");
      else if (i == 5)
        drive(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, V_BUSY, "div_busy_ignores_hazards");
      else if (i < 31)
        idle(V_BUSY, "div_busy");
      else if (i == 31)
        idle(V_DONE, "div_done");
      else
        idle(V_DEF, "div_resume");
      @(negedge clk);
      ent = sb.pop_front(); checks++;
      if (outs !== ent.exp) begin errors++; $display("FAIL %s (cycle %0d): got %b expected %b", ent.name, i, outs, ent.exp); end
      @(posedge clk); #1;
    end
  endtask

  // Multiply with branch in the start cycle, then back-to-back multiply started right after done.
  task automatic test_back_to_back;
    for (int i = 0; i < 10; i++) begin
      case (i)
        0: drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, V_FLUSH, "mul_start_with_branch");
        1, 2: idle(V_BUSY, "mul_busy");
        3: idle(V_DONE, "mul_done");
        4: drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, V_DEF, "mul2_start");
        5, 6: idle(V_BUSY, "mul2_busy");
        7: idle(V_DONE, "mul2_done");
        8: drive(5'd3, 5'd2, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, V_STALL, "load_use_after_mul");
        default: idle(V_DEF, "idle_after_mul");
      endcase
      @(negedge clk);
      ent = sb.pop_front(); checks++;
      if (outs !== ent.exp) begin errors++; $display("FAIL %s (cycle %0d): got %b expected %b", ent.name, i, outs, ent.exp); end
      @(posedge clk); #1;
    end
  endtask

  // Multiply aborted by reset in busy cycle 2: immediate return, never a done pulse.
  task automatic test_mul_reset;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, V_DEF, "mul_start");
        1: idle(V_BUSY, "mul_busy1");
        2: begin rst_n = 1'b0; idle(V_RST, "mul_reset_mid_busy"); end
        default: begin rst_n = 1'b1; idle(V_DEF, "mul_after_reset_no_done"); end
      endcase
      @(negedge clk);
      ent = sb.pop_front(); checks++;
      if (outs !== ent.exp) begin errors++; $display("FAIL %s (cycle %0d): got %b expected %b", ent.name, i, outs, ent.exp); end
      @(posedge clk); #1;
    end
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats;
    rst_n = 1'b0;
    idle(V_RST, "stats_reset");
    @(negedge clk);
    ent = sb.pop_front(); checks++;
    if (outs !== ent.exp) begin errors++; $display("FAIL %s: got %b expected %b", ent.name, outs, ent.exp); end
    checks++;
    if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin
      errors++; $display("FAIL stats_reset_values: got %0d/%0d expected 0/0", stall_cycles, flush_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(5'd5, 5'd3, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, V_STALL, "stats_load_use");
    @(negedge clk); ent = sb.pop_front(); checks++;
    if (outs !== ent.exp) begin errors++; $display("FAIL %s: got %b expected %b", ent.name, outs, ent.exp); end
    @(posedge clk); #1;
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, V_DEF, "stats_div_start");
    @(negedge clk); ent = sb.pop_front(); checks++;
    if (outs !== ent.exp) begin errors++; $display("FAIL %s: got %b expected %b", ent.name, outs, ent.exp); end
    @(posedge clk); #1;
    for (int i = 1; i <= 31; i++) begin
      idle((i == 31) ? V_DONE : V_BUSY, "stats_div");
      @(negedge clk); ent = sb.pop_front(); checks++;
      if (outs !== ent.exp) begin errors++; $display("FAIL %s (cycle %0d): got %b expected %b", ent.name, i, outs, ent.exp); end
      @(posedge clk); #1;
    end
    drive(5'd5, 5'd3, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, V_FLUSH, "stats_branch_load");
    @(negedge clk); ent = sb.pop_front(); checks++;
    if (outs !== ent.exp) begin errors++; $display("FAIL %s: got %b expected %b", ent.name, outs, ent.exp); end
    checks++;
    if (stall_cycles !== 16'd32) begin errors++; $display("FAIL stall_cycles: got %0d expected 32", stall_cycles); end
    @(posedge clk); #1;
    idle(V_DEF, "stats_idle");
    @(negedge clk); ent = sb.pop_front(); checks++;
    if (outs !== ent.exp) begin errors++; $display("FAIL %s: got %b expected %b", ent.name, outs, ent.exp); end
    checks++;
    if (flush_count !== 16'd1) begin errors++; $display("FAIL flush_count: got %0d expected 1", flush_count); end
    checks++;
    if (stall_cycles !== 16'd32) begin errors++; $display("FAIL stall_cycles_hold: got %0d expected 32", stall_cycles); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle(V_RST, "init");
    void'(sb.pop_front());
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_branch_load();
    test_div();
    test_back_to_back();
    test_mul_reset();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
